spi_byte_receiver: RTL and testbench
====================================

# spi_byte_receiver

Host-facing SPI slave (mode 0, MSB first) that deserialises bytes from the external controller and pushes each completed word into the command FIFO's write port. Sits directly upstream of the FIFO: drives its `datain`/`datain_enable`, watches its `full`. Also returns a status byte on MISO so the host can poll FIFO occupancy and overflow without a separate bus.

## Interface
- `DATA_WIDTH`, 8, bits per transferred word; FIFO write width. Must be ≥ 2.
- `clockin`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_sck`  in  1  host SPI clock, asynchronous to `clockin`; idle low.
- `spi_cs_n`  in  1  host chip select, active low, asynchronous.
- `spi_mosi`  in  1  host data in, asynchronous.
- `spi_miso`  out  1  status bit stream to host.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_data`  out  DATA_WIDTH  word to FIFO (`datain`).
- `fifo_write`  out  1  one-cycle write strobe (`datain_enable`).
- `overflow_clear`  in  1  one-cycle pulse, clears `overflow`.
- `overflow`  out  1  sticky: a completed word was dropped because FIFO was full.
- `busy`  out  1  synchronised chip select active.

## Operation
- `spi_sck`, `spi_cs_n`, `spi_mosi` each pass a 2-flop synchroniser plus a third history flop; reset values sck=0, cs_n=1, mosi=0.
- Edge detect on synchronised signals: `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise` (stage 2 vs stage 3). MOSI sampled from same stage as SCK.
- `busy` = inverted synchronised cs_n (stage 2).
- Receive: while busy, on each `sck_rise` shift MOSI into shift register from LSB side (first bit ends in MSB); bit counter 0..DATA_WIDTH-1 increments, wraps to 0 on completion.
- Completion = `sck_rise` with counter == DATA_WIDTH-1. In that cycle: if `fifo_full` low, register `fifo_data` <= assembled word and `fifo_write` <= 1; else `fifo_write` stays 0 and `overflow` <= 1 (word dropped).
- `cs_rise` (deselect): bit counter and shift register cleared, partial word discarded, no write, no overflow.
- `sck_rise` while not busy ignored.
- `overflow`: set by dropped word, cleared by `overflow_clear`; set wins if both in same cycle. Only `reset` or `overflow_clear` clears it.
- Status byte (8 bits regardless of DATA_WIDTH): {5'b0, busy-independent 1'b0, overflow, fifo_full} i.e. bit1 = overflow, bit0 = fifo_full, bits 7..2 = 0.
- MISO: on `cs_fall` load status into TX register, drive bit7. Each `sck_fall` while busy shifts next bit out. After 8 bits, reload fresh status at the next `sck_fall` (continuous polling). `spi_miso` = 0 when not busy.

## Timing
- Reset values: `fifo_write`=0, `fifo_data`=0, `overflow`=0, `spi_miso`=0, `busy`=0, counters/shift/TX registers 0.
- Pin-to-edge latency: 3 `clockin` cycles (2 sync + detect). Completion detected in cycle N -> `fifo_write` high in cycle N+1 only, `fifo_data` valid from N+1, held until next write.
- `fifo_full` sampled in cycle N; between writes at least DATA_WIDTH SCK periods elapse, so no back-to-back strobes.
- Host constraint: SCK high and low phases each ≥ 3 `clockin` periods; CS setup/hold to SCK ≥ 3 `clockin` periods.
- Completion and `cs_rise` detected in same cycle: completion processed (word written or dropped), then counter cleared.
- Reset mid-word: all state to reset values immediately; partial word lost; next transfer requires new `cs_fall`.

## Test plan
- Reset, then CS low, send 0xA5 MSB first, CS high -> exactly one `fifo_write` pulse with `fifo_data`=0xA5, 4 `clockin` after 8th SCK rise at pin; `overflow`=0.
- Three bytes 0x01,0x80,0xFF in one CS frame -> three single-cycle strobes, data in order, counter wraps each time.
- `fifo_full`=1 during 8th bit of 0x3C -> no strobe, `overflow`=1; MISO status on next frame = 0x03; pulse `overflow_clear` -> `overflow`=0, status 0x01 (still full).
- CS high after 5 bits of a byte, then new frame with 0x5A -> no write for partial, single write of 0x5A.
- `overflow_clear` in same cycle as a drop -> `overflow` stays 1.
- Assert `reset` after 4 bits -> outputs at reset values; following full frame 0xC3 writes 0xC3 correctly.

Source files
------------

// File: rtl/spi_byte_receiver.sv
// spi_byte_receiver
// SPI mode-0 slave that deserialises MSB-first words from the host and pushes
// each completed word into the command FIFO write port. While selected, it
// also streams an 8-bit status byte back on MISO so the host can poll the
// FIFO state.
//
// Ports:
//   clockin        system clock, all state on its rising edge
//   reset          asynchronous active-high reset
//   spi_sck        host SPI clock (async, idle low)
//   spi_cs_n       host chip select, active low (async)
//   spi_mosi       host data in (async)
//   spi_miso       status bit stream to host, 0 when not selected
//   fifo_full      FIFO full flag
//   fifo_data      completed word for the FIFO (held until the next write)
//   fifo_write     one-cycle FIFO write strobe
//   overflow_clear one-cycle pulse that clears overflow
//   overflow       sticky flag: a completed word was dropped on a full FIFO
//   busy           synchronised chip select is active
module spi_byte_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clockin,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_write,
  input  logic                  overflow_clear,
  output logic                  overflow,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  // Bit 0 is the first synchroniser flop, bit 1 the usable stage, bit 2 the
  // history used for edge detection. MOSI is only ever sampled from the
  // usable stage, so it needs no history flop.
  logic [2:0] sck_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic [DATA_WIDTH-2:0] partial_word;
  logic [DATA_WIDTH-1:0] assembled;
  logic [CW-1:0]         bit_count;
  logic [7:0]            tx_reg;
  logic [2:0]            tx_count;
  logic [7:0]            status;

  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_rise;
  logic rx_active;
  logic bit_take;
  logic word_done;

  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      sck_sync  <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign cs_fall  = ~cs_sync[1] & cs_sync[2];
  assign cs_rise  = cs_sync[1] & ~cs_sync[2];
  assign busy     = ~cs_sync[1];

  // The history stage keeps reception alive in the cycle where deselect is
  // detected, so a word finishing in that same cycle is still delivered.
  assign rx_active = ~cs_sync[1] | ~cs_sync[2];
  assign bit_take  = sck_rise & rx_active;
  assign word_done = bit_take && (bit_count == LAST_BIT);
  assign assembled = {partial_word, mosi_sync[1]};

  // Shift in one bit per SCK rise; on the last bit hand the word to the FIFO
  // or drop it if the FIFO is full. Deselect discards any partial word, and
  // is placed last so it wins over the counter update in a shared cycle.
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      bit_count    <= '0;
      partial_word <= '0;
      fifo_data    <= '0;
      fifo_write   <= 1'b0;
    end else begin
      fifo_write <= 1'b0;
      if (bit_take) begin
        partial_word <= assembled[DATA_WIDTH-2:0];
        if (word_done) begin
          bit_count <= '0;
          if (!fifo_full) begin
            fifo_data  <= assembled;
            fifo_write <= 1'b1;
          end
        end else begin
          bit_count <= bit_count + 1'b1;
        end
      end
      if (cs_rise) begin
        bit_count    <= '0;
        partial_word <= '0;
      end
    end
  end

  // Sticky drop flag; a new drop takes priority over a clear request.
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (word_done && fifo_full) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  assign status = {6'b000000, overflow, fifo_full};

  // Status transmitter: load on select, shift on each SCK fall, and reload a
  // fresh snapshot after every eighth fall so the host can poll continuously.
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      tx_reg   <= 8'h00;
      tx_count <= 3'd0;
    end else if (cs_fall) begin
      tx_reg   <= status;
      tx_count <= 3'd0;
    end else if (sck_fall && busy) begin
      if (tx_count == 3'd7) begin
        tx_reg   <= status;
        tx_count <= 3'd0;
      end else begin
        tx_reg   <= {tx_reg[6:0], 1'b0};
        tx_count <= tx_count + 3'd1;
      end
    end
  end

  assign spi_miso = busy & tx_reg[7];

endmodule

// File: tb/tb_spi_byte_receiver.sv
// tb_spi_byte_receiver
// Drives SPI frames into spi_byte_receiver and compares the FIFO writes,
// overflow flag and MISO status bytes with a byte-level reference model.
module tb_spi_byte_receiver;

  localparam int W = 8;

  logic         clockin = 1'b0;
  logic         reset = 1'b1;
  logic         spi_sck = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic         fifo_full = 1'b0;
  logic [W-1:0] fifo_data;
  logic         fifo_write;
  logic         overflow_clear = 1'b0;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int long_pulse = 0;
  int last_rise = 0;
  logic prev_write = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         wcyc_q[$];

  logic [7:0] miso_shift = 8'h00;
  logic [7:0] status_rx = 8'h00;
  logic       model_ovf = 1'b0;
  logic [7:0] frame_data[4];
  logic       frame_full[4];
  int         frame_len = 0;

  spi_byte_receiver #(.DATA_WIDTH(W)) dut (
    .clockin       (clockin),
    .reset         (reset),
    .spi_sck       (spi_sck),
    .spi_cs_n      (spi_cs_n),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .fifo_full     (fifo_full),
    .fifo_data     (fifo_data),
    .fifo_write    (fifo_write),
    .overflow_clear(overflow_clear),
    .overflow      (overflow),
    .busy          (busy)
  );

  always #5 clockin = ~clockin;

  always @(posedge clockin) cyc <= cyc + 1;

  // Record every write strobe seen on the FIFO port and any strobe that
  // lasts longer than one cycle.
  always @(negedge clockin) begin
    if (fifo_write === 1'b1) begin
      got_q.push_back(fifo_data);
      wcyc_q.push_back(cyc);
      if (prev_write === 1'b1) long_pulse++;
    end
    prev_write = fifo_write;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clockin);
    #1;
  endtask

  // One SCK period: set MOSI, low phase, sample MISO, high phase. Optionally
  // pulses overflow_clear in the cycle the DUT registers this rising edge.
  task automatic drive_bit(input logic b, input logic clr);
    spi_mosi = b;
    tick(4);
    miso_shift = {miso_shift[6:0], spi_miso};
    spi_sck = 1'b1;
    last_rise = cyc;
    if (clr) begin
      tick(2);
      overflow_clear = 1'b1;
      tick(1);
      overflow_clear = 1'b0;
      tick(1);
    end else begin
      tick(4);
    end
    spi_sck = 1'b0;
  endtask

  // Sends frame_data[0..frame_len-1] in one CS frame and advances the model.
  task automatic run_frame(input logic clr_last);
    logic [7:0] d;
    fifo_full = frame_full[0];
    spi_cs_n = 1'b0;
    tick(5);
    for (int j = 0; j < frame_len; j++) begin
      fifo_full = frame_full[j];
      d = frame_data[j];
      for (int i = 7; i >= 0; i--)
        drive_bit(d[i], clr_last && (j == frame_len - 1) && (i == 0));
      if (j == 0) status_rx = miso_shift;
      if (frame_full[j]) model_ovf = 1'b1;
      else exp_q.push_back(d);
    end
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
  endtask

  task automatic pulse_clear();
    overflow_clear = 1'b1;
    tick(1);
    overflow_clear = 1'b0;
    tick(1);
    model_ovf = 1'b0;
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    wcyc_q.delete();
    long_pulse = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    total++; if (fifo_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_write got=%b exp=0", fifo_write); end
    total++; if (fifo_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00", fifo_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL reset_miso got=%b exp=0", spi_miso); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick(4);
  endtask

  task automatic test_single_byte();
    clear_queues();
    frame_len = 1; frame_data[0] = 8'hA5; frame_full[0] = 1'b0;
    run_frame(1'b0);
    total++; if (got_q.size() !== 1) begin bad++; $display("[TB] FAIL single_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== 8'hA5) begin bad++; $display("[TB] FAIL single_data got=%h exp=a5", got_q[0]); end
      // Two synchroniser stages plus one registered stage after the pin edge.
      total++;
      if (wcyc_q[0] - last_rise < 3 || wcyc_q[0] - last_rise > 4) begin
        bad++; $display("[TB] FAIL single_latency got=%0d exp=3..4", wcyc_q[0] - last_rise);
      end
    end
    total++; if (long_pulse !== 0) begin bad++; $display("[TB] FAIL single_pulse_width got=%0d exp=0", long_pulse); end
    total++; if (fifo_data !== 8'hA5) begin bad++; $display("[TB] FAIL single_hold got=%h exp=a5", fifo_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL single_overflow got=%b exp=0", overflow); end
    total++; if (status_rx !== 8'h00) begin bad++; $display("[TB] FAIL single_status got=%h exp=00", status_rx); end
  endtask

  task automatic test_multi_byte();
    clear_queues();
    frame_len = 3;
    frame_data[0] = 8'h01; frame_data[1] = 8'h80; frame_data[2] = 8'hFF;
    for (int j = 0; j < 3; j++) frame_full[j] = 1'b0;
    run_frame(1'b0);
    total++; if (got_q.size() !== 3) begin bad++; $display("[TB] FAIL multi_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL multi_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (long_pulse !== 0) begin bad++; $display("[TB] FAIL multi_pulse_width got=%0d exp=0", long_pulse); end
  endtask

  task automatic test_overflow();
    clear_queues();
    frame_len = 1; frame_data[0] = 8'h3C; frame_full[0] = 1'b1;
    run_frame(1'b0);
    total++; if (got_q.size() !== 0) begin bad++; $display("[TB] FAIL ovf_no_write got=%0d exp=0", got_q.size()); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_set got=%b exp=1", overflow); end
    frame_data[0] = 8'h42;
    run_frame(1'b0);
    total++; if (status_rx !== 8'h03) begin bad++; $display("[TB] FAIL ovf_status got=%h exp=03", status_rx); end
    pulse_clear();
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
    frame_data[0] = 8'h99;
    run_frame(1'b0);
    total++; if (status_rx !== 8'h01) begin bad++; $display("[TB] FAIL ovf_status_full got=%h exp=01", status_rx); end
    pulse_clear();
    fifo_full = 1'b0;
    tick(2);
  endtask

  task automatic test_partial_abort();
    clear_queues();
    spi_cs_n = 1'b0;
    tick(5);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    tick(4);
    spi_cs_n = 1'b1;
    tick(6);
    total++; if (got_q.size() !== 0) begin bad++; $display("[TB] FAIL partial_no_write got=%0d exp=0", got_q.size()); end
    frame_len = 1; frame_data[0] = 8'h5A; frame_full[0] = 1'b0;
    run_frame(1'b0);
    total++; if (got_q.size() !== 1) begin bad++; $display("[TB] FAIL partial_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== 8'h5A) begin bad++; $display("[TB] FAIL partial_data got=%h exp=5a", got_q[0]); end
    end
  endtask

  task automatic test_clear_collision();
    clear_queues();
    frame_len = 1; frame_data[0] = 8'h77; frame_full[0] = 1'b1;
    run_frame(1'b0);
    frame_data[0] = 8'h11;
    run_frame(1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL collision_overflow got=%b exp=1", overflow); end
    total++; if (got_q.size() !== 0) begin bad++; $display("[TB] FAIL collision_no_write got=%0d exp=0", got_q.size()); end
    pulse_clear();
    fifo_full = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL collision_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_midword();
    clear_queues();
    spi_cs_n = 1'b0;
    tick(5);
    for (int i = 0; i < 4; i++) drive_bit(i[0], 1'b0);
    reset = 1'b1;
    tick(1);
    total++; if (fifo_data !== 8'h00) begin bad++; $display("[TB] FAIL midreset_data got=%h exp=00", fifo_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("[TB] FAIL midreset_miso got=%b exp=0", spi_miso); end
    spi_cs_n = 1'b1;
    tick(2);
    reset = 1'b0;
    model_ovf = 1'b0;
    tick(4);
    frame_len = 1; frame_data[0] = 8'hC3; frame_full[0] = 1'b0;
    run_frame(1'b0);
    total++; if (got_q.size() !== 1) begin bad++; $display("[TB] FAIL midreset_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== 8'hC3) begin bad++; $display("[TB] FAIL midreset_frame got=%h exp=c3", got_q[0]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_status;
    clear_queues();
    for (int f = 0; f < 8; f++) begin
      frame_len = $urandom_range(1, 3);
      for (int j = 0; j < frame_len; j++) begin
        frame_data[j] = 8'($urandom);
        frame_full[j] = ($urandom_range(0, 3) == 0);
      end
      exp_status = {6'b000000, model_ovf, frame_full[0]};
      run_frame(1'b0);
      total++; if (status_rx !== exp_status) begin bad++; $display("[TB] FAIL rand_status[%0d] got=%h exp=%h", f, status_rx, exp_status); end
      total++; if (overflow !== model_ovf) begin bad++; $display("[TB] FAIL rand_overflow[%0d] got=%b exp=%b", f, overflow, model_ovf); end
      if ($urandom_range(0, 1) == 1) pulse_clear();
    end
    fifo_full = 1'b0;
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("[TB] FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rand_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (long_pulse !== 0) begin bad++; $display("[TB] FAIL rand_pulse_width got=%0d exp=0", long_pulse); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_overflow();
    test_partial_abort();
    test_clear_collision();
    test_reset_midword();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
